// File: rtl/constraint_sampler_pkg.sv
// Shared types and constants for the constraint sampler.
// Holds the FSM state encoding and LFSR geometry.
package constraint_sampler_pkg;

  localparam int LFSR_W = 32;

  localparam logic [LFSR_W-1:0] LFSR_TAPS =
    32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_adv(
    input logic [LFSR_W-1:0] s
  );
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/constraint_sampler_if.sv
// Valid/ready output channel carrying accepted candidates.
// The sampler drives the master side.
interface constraint_sampler_if #(
  parameter int WIDTH = 16
);

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/constraint_sampler_lfsr.sv
// 32-bit right-shifting Galois LFSR with seed load.
// A zero seed is replaced by 1 to keep the register live.
module sampler_lfsr
  import constraint_sampler_pkg::*;
#(
  parameter int                WIDTH = 16,
  parameter logic [LFSR_W-1:0] SEED  = 32'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [WIDTH-1:0]  next_cand
);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt;

  assign lfsr_nxt  = lfsr_adv(lfsr);
  assign next_cand = lfsr_nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= (seed == '0) ? 32'h1 : seed;
    end else if (step) begin
      lfsr <= lfsr_nxt;
    end
  end

endmodule

// File: rtl/constraint_sampler.sv
// Candidate generator driving a combinational constraint checker.
// Optional counters: define CONSTRAINT_SAMPLER_STATS_EN.
module constraint_sampler
  import constraint_sampler_pkg::*;
#(
  parameter int                WIDTH     = 16,
  parameter int                MAX_TRIES = 255,
  parameter logic [LFSR_W-1:0] SEED      = 32'h0000_0001,
  localparam int               TW        = $clog2(MAX_TRIES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  seed_load,
  input  logic [31:0]           seed,
  output logic [WIDTH-1:0]      cand,
  input  logic                  sat,
  constraint_sampler_if.master  out,
  output logic                  busy,
  output logic                  fail,
  output logic [TW-1:0]         try_count,
  output logic [31:0]           acc_total,
  output logic [31:0]           rej_total
);

  localparam logic [TW-1:0] MAX_T = TW'(MAX_TRIES);

  state_e           state;
  logic [WIDTH-1:0] next_cand;
  logic             at_max;
  logic             is_idle;
  logic             is_check;
  logic             lfsr_load;
  logic             lfsr_step;

  assign is_idle   = (state == ST_IDLE);
  assign is_check  = (state == ST_CHECK);
  assign at_max    = (try_count == MAX_T);
  assign lfsr_load = is_idle && seed_load;
  // The LFSR advances exactly when a fresh candidate is loaded.
  assign lfsr_step = (is_idle && start && !seed_load) ||
                     (is_check && !sat && !at_max);

  sampler_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load      (lfsr_load),
    .seed      (seed),
    .step      (lfsr_step),
    .next_cand (next_cand)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cand          <= '0;
      out.out_data  <= '0;
      out.out_valid <= 1'b0;
      busy          <= 1'b0;
      fail          <= 1'b0;
      try_count     <= '0;
    end else begin
      fail <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start && !seed_load) begin
            cand      <= next_cand;
            try_count <= TW'(1);
            busy      <= 1'b1;
            state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (sat) begin
            out.out_data  <= cand;
            out.out_valid <= 1'b1;
            state         <= ST_HOLD;
          end else if (at_max) begin
            fail  <= 1'b1;
            state <= ST_FAIL;
          end else begin
            cand      <= next_cand;
            try_count <= try_count + 1'b1;
          end
        end
        ST_HOLD: begin
          if (out.out_ready) begin
            out.out_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        ST_FAIL: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CONSTRAINT_SAMPLER_STATS_EN
  logic [31:0] acc_q;
  logic [31:0] rej_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      rej_q <= '0;
    end else if (is_check) begin
      if (sat && acc_q != '1) begin
        acc_q <= acc_q + 32'd1;
      end
      if (!sat && rej_q != '1) begin
        rej_q <= rej_q + 32'd1;
      end
    end
  end

  assign acc_total = acc_q;
  assign rej_total = rej_q;
`else
  assign acc_total = '0;
  assign rej_total = '0;
`endif

endmodule

// File: tb/tb_constraint_sampler.sv
// Directed bench for constraint_sampler with a scoreboard
// monitor on the output handshake.
module tb_constraint_sampler;

  localparam int W  = 16;
  localparam int MT = 4;
  localparam int TW = $clog2(MT + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          seed_load;
  logic [31:0]   seed;
  logic [W-1:0]  cand;
  logic          sat;
  logic          busy;
  logic          fail;
  logic [TW-1:0] try_count;
  logic [31:0]   acc_total;
  logic [31:0]   rej_total;
  int            mode;

  int tests = 0;
  int fails = 0;
  int xfers = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  m;
  int           e_acc;
  int           e_rej;

  constraint_sampler_if #(.WIDTH(W)) bus ();

  constraint_sampler #(
    .WIDTH     (W),
    .MAX_TRIES (MT),
    .SEED      (32'h1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed_load (seed_load),
    .seed      (seed),
    .cand      (cand),
    .sat       (sat),
    .out       (bus),
    .busy      (busy),
    .fail      (fail),
    .try_count (try_count),
    .acc_total (acc_total),
    .rej_total (rej_total)
  );

  always #5 clk = ~clk;

  assign sat = (mode == 0) ? 1'b0 :
               (mode == 1) ? 1'b1 :
               |(cand - 16'h1bde);

  function automatic logic [31:0] step(input logic [31:0] s);
    logic [31:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ 32'h8020_0003;
    return t;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string name);
`ifdef CONSTRAINT_SAMPLER_STATS_EN
    check({name, "_acc"}, acc_total, 32'(e_acc));
    check({name, "_rej"}, rej_total, 32'(e_rej));
`else
    check({name, "_acc"}, acc_total, 32'h0);
    check({name, "_rej"}, rej_total, 32'h0);
`endif
  endtask

  // Scoreboard monitor: a transfer is valid && ready at the falling edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      xfers++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got %h expected none",
                 bus.out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          fails++;
          $display("FAIL sb_data: got %h expected %h",
                   bus.out_data, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    seed_load = 1'b0;
    seed = '0;
    mode = 1;
    bus.out_ready = 1'b1;
    e_acc = 0;
    e_rej = 0;
    m = 32'h1;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_cand", 32'(cand), 0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data", 32'(bus.out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_try", 32'(try_count), 0);
    check("rst_lfsr", dut.u_lfsr.lfsr, 32'h1);
    check_stats("rst");

    // First candidate with sat tied high
    mode = 1;
    exp_q.push_back(16'h0003);
    start = 1'b1;
    tick();
    start = 1'b0;
    m = step(m);
    check("first_cand", 32'(cand), 32'h0003);
    check("first_busy", 32'(busy), 1);
    check("first_try", 32'(try_count), 1);
    tick();
    e_acc++;
    check("first_valid", 32'(bus.out_valid), 1);
    check("first_data", 32'(bus.out_data), 32'h0003);
    tick();
    check("first_done", 32'(bus.out_valid), 0);
    check("first_idle", 32'(busy), 0);

    // Real checker: first candidate 1bde is rejected
    mode = 2;
    seed_load = 1'b1;
    seed = 32'h0000_37bc;
    tick();
    seed_load = 1'b0;
    m = 32'h0000_37bc;
    check("chk_seed", dut.u_lfsr.lfsr, 32'h0000_37bc);
    exp_q.push_back(16'h0def);
    start = 1'b1;
    tick();
    start = 1'b0;
    m = step(m);
    check("chk_cand1", 32'(cand), 32'h1bde);
    tick();
    m = step(m);
    e_rej++;
    check("chk_cand2", 32'(cand), 32'h0def);
    check("chk_try", 32'(try_count), 2);
    tick();
    e_acc++;
    check("chk_valid", 32'(bus.out_valid), 1);
    check("chk_data", 32'(bus.out_data), 32'h0def);
    check("chk_not_bad", 32'(bus.out_data != 16'h1bde), 1);
    tick();

    // Budget exhaustion
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    m = step(m);
    check("ex_cand1", 32'(cand), 32'(m[W-1:0]));
    for (int i = 2; i <= MT; i++) begin
      tick();
      m = step(m);
      check("ex_cand", 32'(cand), 32'(m[W-1:0]));
      check("ex_try", 32'(try_count), 32'(i));
      check("ex_nofail", 32'(fail), 0);
      check("ex_novalid", 32'(bus.out_valid), 0);
    end
    tick();
    e_rej += MT;
    check("ex_fail", 32'(fail), 1);
    check("ex_try_max", 32'(try_count), MT);
    check("ex_novalid2", 32'(bus.out_valid), 0);
    tick();
    check("ex_fail_off", 32'(fail), 0);
    check("ex_idle", 32'(busy), 0);
    check("ex_try_hold", 32'(try_count), MT);

    // Backpressure in HOLD, start pulses ignored
    mode = 1;
    bus.out_ready = 1'b0;
    m = step(m);
    exp_q.push_back(m[W-1:0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    e_acc++;
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      check("bp_valid", 32'(bus.out_valid), 1);
      check("bp_data", 32'(bus.out_data), 32'(m[W-1:0]));
      check("bp_cand", 32'(cand), 32'(m[W-1:0]));
      tick();
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_drop", 32'(bus.out_valid), 0);
    check("bp_idle", 32'(busy), 0);
    tick();
    tick();
    check("bp_no_rerun", 32'(busy), 0);
    check("bp_xfers", 32'(xfers), 3);
    check_stats("bp");

    // Zero seed with competing start, then reset mid-run
    mode = 0;
    seed_load = 1'b1;
    seed = 32'h0;
    start = 1'b1;
    tick();
    seed_load = 1'b0;
    start = 1'b0;
    check("z_lfsr", dut.u_lfsr.lfsr, 32'h1);
    check("z_busy", 32'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("z_cand", 32'(cand), 32'h0003);
    check("z_busy2", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e_acc = 0;
    e_rej = 0;
    check("mr_busy", 32'(busy), 0);
    check("mr_try", 32'(try_count), 0);
    check("mr_cand", 32'(cand), 0);
    check("mr_lfsr", dut.u_lfsr.lfsr, 32'h1);
    check_stats("mr");
    tick();
    check("end_queue", 32'(exp_q.size()), 0);
    check("end_xfers", 32'(xfers), 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
